ace_snoop_responder: RTL

ACE_SNOOP_RESPONDER -- requirements
Module: ace_snoop_responder

---
 rtl/ace_snoop_responder.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: tracks a small set of cached lines, answers AC snoops on CR and streams line data on CD.
// Define SNOOP_ERR_EN to answer unsupported snoop opcodes with an Error-only response instead of all-zero.

`ifndef SNOOP_ADD_BUS_WIDTH
`define SNOOP_ADD_BUS_WIDTH 32
`endif
`ifndef SNOOP_DATA_BUS_WIDTH
`define SNOOP_DATA_BUS_WIDTH 64
`endif

module ace_snoop_responder #(
  parameter int NUM_LINES   = 8,
  parameter int LINE_BEATS  = 4,
  parameter int ADDR_W      = `SNOOP_ADD_BUS_WIDTH,
  parameter int DATA_W      = `SNOOP_DATA_BUS_WIDTH,
  parameter int OFFSET_BITS = 5,
  localparam int IDX_W  = $clog2(NUM_LINES),
  localparam int BEAT_W = $clog2(LINE_BEATS),
  localparam int TAG_W  = ADDR_W - OFFSET_BITS
) (
  input  logic              aclk,
  input  logic              arst,
  input  logic              ac_valid,
  output logic              ac_ready,
  input  logic [ADDR_W-1:0] ac_addr,
  input  logic [3:0]        ac_snoop,
  input  logic [2:0]        ac_prot,
  output logic              cr_valid,
  input  logic              cr_ready,
  output logic [4:0]        cr_resp,
  output logic              cd_valid,
  input  logic              cd_ready,
  output logic [DATA_W-1:0] cd_data,
  output logic              cd_last,
  input  logic              ln_wr_en,
  input  logic [IDX_W-1:0]  ln_wr_idx,
  input  logic [TAG_W-1:0]  ln_wr_tag,
  input  logic [2:0]        ln_wr_state,
  output logic [IDX_W-1:0]  rd_idx,
  output logic [BEAT_W-1:0] rd_beat,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy
);

  localparam logic [2:0] ST_I  = 3'd0;
  localparam logic [2:0] ST_UC = 3'd1;
  localparam logic [2:0] ST_UD = 3'd2;
  localparam logic [2:0] ST_SC = 3'd3;
  localparam logic [2:0] ST_SD = 3'd4;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, RESP, DPREP, DATA} state_t;

  state_t state, state_nxt;

  logic [TAG_W-1:0]  tag_q [NUM_LINES];
  logic [2:0]        st_q  [NUM_LINES];

  logic [TAG_W-1:0]  tag_r;
  logic [3:0]        snoop_r;
  logic [IDX_W-1:0]  hit_idx_r;
  logic [4:0]        resp_r;
  logic [2:0]        new_st_r;
  logic              upd_r;
  logic [BEAT_W-1:0] beat_r;

  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic [2:0]        hit_st;
  logic              was_unique;
  logic              dirty;
  logic [4:0]        resp;
  logic [2:0]        nxt_st;
  logic              upd;
  logic              ac_fire;

  logic unused_bits;
  assign unused_bits = ^{ac_prot, ac_addr[OFFSET_BITS-1:0]};

  assign ac_fire = ac_valid && ac_ready;
  assign cd_data = rd_data;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_st  = ST_I;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (st_q[i] != ST_I && tag_q[i] == tag_r) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
        hit_st  = st_q[i];
      end
    end
  end

  always_comb begin
    was_unique = hit && (hit_st == ST_UC || hit_st == ST_UD);
    dirty      = hit && (hit_st == ST_UD || hit_st == ST_SD);
    resp       = '0;
    nxt_st     = hit_st;
    upd        = 1'b0;
    case (snoop_r)
      4'b0000: if (hit) resp = {was_unique, 1'b1, 1'b0, 1'b0, 1'b1};
      4'b0001, 4'b0010, 4'b0011: if (hit) begin
        resp   = {was_unique, 1'b1, dirty, 1'b0, 1'b1};
        nxt_st = ST_SC;
        upd    = 1'b1;
      end
      4'b0111: if (hit) begin
        resp   = {was_unique, 1'b0, dirty, 1'b0, 1'b1};
        nxt_st = ST_I;
        upd    = 1'b1;
      end
      4'b1001: if (hit) begin
        resp   = {was_unique, 1'b0, dirty, 1'b0, dirty};
        nxt_st = ST_I;
        upd    = 1'b1;
      end
      4'b1000: if (hit) begin
        resp = {was_unique, 1'b1, dirty, 1'b0, dirty};
        upd  = 1'b1;
        if (hit_st == ST_UD) nxt_st = ST_UC;
        else if (hit_st == ST_SD) nxt_st = ST_SC;
      end
      4'b1101: if (hit) begin
        resp   = {was_unique, 4'b0000};
        nxt_st = ST_I;
        upd    = 1'b1;
      end
      default: begin
`ifdef SNOOP_ERR_EN
        resp = 5'b00010;
`else
        resp = 5'b00000;
`endif
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ac_ready  = 1'b0;
    cr_valid  = 1'b0;
    cr_resp   = '0;
    cd_valid  = 1'b0;
    cd_last   = 1'b0;
    busy      = 1'b1;
    rd_idx    = '0;
    rd_beat   = beat_r;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        ac_ready = !arst;
        if (ac_valid && !arst) state_nxt = LOOKUP;
      end
      LOOKUP: state_nxt = RESP;
      RESP: begin
        cr_valid = 1'b1;
        cr_resp  = resp_r;
        if (cr_ready) state_nxt = resp_r[0] ? DPREP : IDLE;
      end
      DPREP: begin
        rd_idx    = hit_idx_r;
        state_nxt = DATA;
      end
      DATA: begin
        rd_idx   = hit_idx_r;
        cd_valid = 1'b1;
        cd_last  = (beat_r == LAST_BEAT);
        // Look ahead one beat so rd_data lines up with the advanced counter.
        if (cd_ready && !cd_last) rd_beat = beat_r + BEAT_W'(1);
        if (cd_ready && cd_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i] <= '0;
        st_q[i]  <= ST_I;
      end
      tag_r     <= '0;
      snoop_r   <= '0;
      hit_idx_r <= '0;
      resp_r    <= '0;
      new_st_r  <= ST_I;
      upd_r     <= 1'b0;
      beat_r    <= '0;
    end else begin
      if (ln_wr_en && !busy) begin
        tag_q[ln_wr_idx] <= ln_wr_tag;
        st_q[ln_wr_idx]  <= ln_wr_state;
      end
      if (ac_fire) begin
        tag_r   <= ac_addr[ADDR_W-1:OFFSET_BITS];
        snoop_r <= ac_snoop;
      end
      if (state == LOOKUP) begin
        hit_idx_r <= hit_idx;
        resp_r    <= resp;
        new_st_r  <= nxt_st;
        upd_r     <= upd;
      end
      if (state == RESP && cr_ready && upd_r) st_q[hit_idx_r] <= new_st_r;
      if (state == DATA && cd_ready) beat_r <= cd_last ? '0 : beat_r + BEAT_W'(1);
    end
  end

endmodule
